myproject_mul_pipe: RTL and testbench



---
 rtl/myproject_mul_pkg.sv | 39 +++
 rtl/myproject_mul_if.sv | 38 +++
 rtl/myproject_mul_lane.sv | 118 +++++++++++
 rtl/myproject_mul_pipe.sv | 96 +++++++++
 tb/tb_myproject_mul_pipe.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/myproject_mul_pkg.sv
// ============================================================================
// Module   : myproject_mul_pkg
// Brief    : Shared width, saturation-limit and parameter-legality helpers
//            for the pipelined multi-lane multiplier.
// Revision : 1.0
// ============================================================================
`default_nettype none

package myproject_mul_pkg;

  localparam int SAT_LIM_W = 128;

  function automatic int prod_width(input int w0, input int w1);
    return w0 + w1;
  endfunction

  function automatic logic [SAT_LIM_W-1:0] sat_umax(input int w);
    return (SAT_LIM_W'(1) << w) - SAT_LIM_W'(1);
  endfunction

  function automatic logic [SAT_LIM_W-1:0] sat_smax(input int w);
    return (SAT_LIM_W'(1) << (w - 1)) - SAT_LIM_W'(1);
  endfunction

  // ~(2^(w-1)-1) is -2^(w-1) in two's complement at any truncation >= w
  function automatic logic [SAT_LIM_W-1:0] sat_smin(input int w);
    return ~sat_smax(w);
  endfunction

  function automatic bit params_legal(input int w0, input int w1, input int wd,
                                      input int lanes, input int stages,
                                      input int tagw);
    return (wd >= 1) && (wd <= prod_width(w0, w1)) && (stages >= 2) &&
           (lanes >= 1) && (tagw >= 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/myproject_mul_if.sv
// ============================================================================
// Module   : myproject_mul_if
// Brief    : Valid/ready operand and result bundle for myproject_mul_pipe.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface myproject_mul_if #(
  parameter int DIN0_WIDTH = 19,
  parameter int DIN1_WIDTH = 17,
  parameter int DOUT_WIDTH = 36,
  parameter int NUM_LANE   = 1,
  parameter int TAG_WIDTH  = 8
) ();

  logic                           in_valid;
  logic                           in_ready;
  logic [NUM_LANE*DIN0_WIDTH-1:0] din0;
  logic [NUM_LANE*DIN1_WIDTH-1:0] din1;
  logic [TAG_WIDTH-1:0]           in_tag;
  logic                           out_valid;
  logic                           out_ready;
  logic [NUM_LANE*DOUT_WIDTH-1:0] dout;
  logic [TAG_WIDTH-1:0]           out_tag;

  modport master (
    output in_valid, din0, din1, in_tag, out_ready,
    input  in_ready, out_valid, dout, out_tag
  );

  modport slave (
    input  in_valid, din0, din1, in_tag, out_ready,
    output in_ready, out_valid, dout, out_tag
  );

endinterface

`default_nettype wire

// File: rtl/myproject_mul_lane.sv
// ============================================================================
// Module   : myproject_mul_lane
// Brief    : One multiplier lane: operand register, full-product register,
//            width reduction and result delay chain. MYPROJECT_MUL_SAT_EN
//            selects saturating instead of wrapping width reduction.
// Revision : 1.0
// ============================================================================
`default_nettype none

module myproject_mul_lane
  import myproject_mul_pkg::*;
#(
  parameter int DIN0_WIDTH = 19,
  parameter int DIN1_WIDTH = 17,
  parameter int DOUT_WIDTH = 36,
  parameter int NUM_STAGE  = 3,
  parameter int SIGNED     = 0
) (
  input  wire logic                  ap_clk,
  input  wire logic                  ap_rst,
  input  wire logic [NUM_STAGE-1:0]  ld,
  input  wire logic [DIN0_WIDTH-1:0] a,
  input  wire logic [DIN1_WIDTH-1:0] b,
  output logic      [DOUT_WIDTH-1:0] y
);

  localparam int PW = prod_width(DIN0_WIDTH, DIN1_WIDTH);

  logic [DIN0_WIDTH-1:0] a_r;
  logic [DIN1_WIDTH-1:0] b_r;
  logic [PW-1:0]         prod;
  logic [PW-1:0]         p_r;
  logic [DOUT_WIDTH-1:0] red;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      a_r <= '0;
      b_r <= '0;
      p_r <= '0;
    end else begin
      if (ld[0]) begin
        a_r <= a;
        b_r <= b;
      end
      if (ld[1]) begin
        p_r <= prod;
      end
    end
  end

  if (SIGNED != 0) begin : g_signed
    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    assign a_ext = PW'(signed'(a_r));
    assign b_ext = PW'(signed'(b_r));
    assign prod  = a_ext * b_ext;
  end else begin : g_unsigned
    assign prod = PW'(a_r) * PW'(b_r);
  end

  if (DOUT_WIDTH == PW) begin : g_full
    assign red = p_r;
  end else begin : g_narrow
`ifdef MYPROJECT_MUL_SAT_EN
    if (SIGNED != 0) begin : g_ssat
      logic [PW-DOUT_WIDTH:0] hi;
      assign hi = p_r[PW-1:DOUT_WIDTH-1];
      // In range exactly when every bit above the result sign bit matches it
      always_comb begin
        red = p_r[DOUT_WIDTH-1:0];
        if (!((&hi) || (~|hi))) begin
          red = p_r[PW-1] ? DOUT_WIDTH'(sat_smin(DOUT_WIDTH))
                          : DOUT_WIDTH'(sat_smax(DOUT_WIDTH));
        end
      end
    end else begin : g_usat
      always_comb begin
        red = p_r[DOUT_WIDTH-1:0];
        if (|p_r[PW-1:DOUT_WIDTH]) begin
          red = DOUT_WIDTH'(sat_umax(DOUT_WIDTH));
        end
      end
    end
`else
    logic unused_p_hi;
    assign unused_p_hi = ^p_r[PW-1:DOUT_WIDTH];
    assign red         = p_r[DOUT_WIDTH-1:0];
`endif
  end

  if (NUM_STAGE > 2) begin : g_delay
    logic [DOUT_WIDTH-1:0] dly [2:NUM_STAGE-1];

    always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
        for (int k = 2; k < NUM_STAGE; k++) begin
          dly[k] <= '0;
        end
      end else begin
        if (ld[2]) begin
          dly[2] <= red;
        end
        for (int k = 3; k < NUM_STAGE; k++) begin
          if (ld[k]) begin
            dly[k] <= dly[k-1];
          end
        end
      end
    end

    assign y = dly[NUM_STAGE-1];
  end else begin : g_nodelay
    assign y = red;
  end

endmodule

`default_nettype wire

// File: rtl/myproject_mul_pipe.sv
// ============================================================================
// Module   : myproject_mul_pipe
// Brief    : NUM_LANE pipelined multipliers under one bubble-collapsing
//            valid/ready controller with a pass-through tag.
//            Build option: MYPROJECT_MUL_SAT_EN (saturating width reduction).
// Revision : 1.0
// ============================================================================
`default_nettype none

module myproject_mul_pipe
  import myproject_mul_pkg::*;
#(
  parameter int DIN0_WIDTH = 19,
  parameter int DIN1_WIDTH = 17,
  parameter int DOUT_WIDTH = 36,
  parameter int NUM_LANE   = 1,
  parameter int NUM_STAGE  = 3,
  parameter int SIGNED     = 0,
  parameter int TAG_WIDTH  = 8
) (
  input wire logic       ap_clk,
  input wire logic       ap_rst,
  myproject_mul_if.slave bus
);

  if (!params_legal(DIN0_WIDTH, DIN1_WIDTH, DOUT_WIDTH, NUM_LANE, NUM_STAGE,
                    TAG_WIDTH)) begin : g_param_err
    $error("myproject_mul_pipe: illegal parameter combination");
  end

  logic [NUM_STAGE-1:0]           v;
  logic [NUM_STAGE-1:0]           adv;
  logic [NUM_STAGE-1:0]           vin;
  logic [NUM_STAGE-1:0]           ld;
  logic [TAG_WIDTH-1:0]           tag_r [NUM_STAGE];
  logic [NUM_LANE*DOUT_WIDTH-1:0] dout_w;

  // A stage may advance unless it and every stage downstream are full and
  // the consumer is stalling.
  always_comb begin : adv_chain
    logic tail_full;
    tail_full = 1'b1;
    adv       = '0;
    for (int k = NUM_STAGE - 1; k >= 0; k--) begin
      tail_full = tail_full & v[k];
      adv[k]    = ~tail_full | bus.out_ready;
    end
  end

  assign vin = {v[NUM_STAGE-2:0], bus.in_valid};
  assign ld  = adv & vin;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      v <= '0;
      for (int k = 0; k < NUM_STAGE; k++) begin
        tag_r[k] <= '0;
      end
    end else begin
      v <= (v & ~adv) | (vin & adv);
      if (ld[0]) begin
        tag_r[0] <= bus.in_tag;
      end
      for (int k = 1; k < NUM_STAGE; k++) begin
        if (ld[k]) begin
          tag_r[k] <= tag_r[k-1];
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_LANE; i++) begin : g_lane
    myproject_mul_lane #(
      .DIN0_WIDTH (DIN0_WIDTH),
      .DIN1_WIDTH (DIN1_WIDTH),
      .DOUT_WIDTH (DOUT_WIDTH),
      .NUM_STAGE  (NUM_STAGE),
      .SIGNED     (SIGNED)
    ) u_lane (
      .ap_clk (ap_clk),
      .ap_rst (ap_rst),
      .ld     (ld),
      .a      (bus.din0[i*DIN0_WIDTH +: DIN0_WIDTH]),
      .b      (bus.din1[i*DIN1_WIDTH +: DIN1_WIDTH]),
      .y      (dout_w[i*DOUT_WIDTH +: DOUT_WIDTH])
    );
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = v[NUM_STAGE-1];
  assign bus.out_tag   = tag_r[NUM_STAGE-1];
  assign bus.dout      = dout_w;

endmodule

`default_nettype wire

// File: tb/tb_myproject_mul_pipe.sv
// ============================================================================
// Module   : tb_myproject_mul_pipe
// Brief    : Three configurations (unsigned, signed, 2-lane 16-bit) driven by
//            shared stimulus and checked against a transaction-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_myproject_mul_pipe;

  localparam int NS = 3;

`ifdef MYPROJECT_MUL_SAT_EN
  localparam logic [63:0] SAT_EXP = 64'h0100_FFFF;
`else
  localparam logic [63:0] SAT_EXP = 64'h0100_0000;
`endif

  typedef struct {
    int          t;
    logic [63:0] e;
    logic [7:0]  g;
  } ent_t;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        in_valid;
  logic        out_ready;
  logic [37:0] din0_all;
  logic [33:0] din1_all;
  logic [7:0]  in_tag;
  logic        final_chk;

  logic [2:0]       valid_w;
  logic [2:0]       ready_w;
  logic [2:0][63:0] dout_w;
  logic [2:0][7:0]  tag_w;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 ap_clk = ~ap_clk;

  function automatic int cfg_dout(input int c);
    return (c == 2) ? 16 : 36;
  endfunction

  function automatic int cfg_lanes(input int c);
    return (c == 2) ? 2 : 1;
  endfunction

  function automatic int cfg_signed(input int c);
    return (c == 1) ? 1 : 0;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Arithmetic reference: integer product per lane, then wrap or clamp.
  function automatic logic [63:0] model(input logic [37:0] a_all, input logic [33:0] b_all,
                                        input int lanes, input int dw, input int sgn);
    logic [63:0] res;
    logic [18:0] a;
    logic [16:0] b;
    longint      pa, pb, p;
`ifdef MYPROJECT_MUL_SAT_EN
    longint      hi, lo;
`endif
    res = '0;
    for (int l = 0; l < lanes; l++) begin
      a  = a_all[l*19 +: 19];
      b  = b_all[l*17 +: 17];
      pa = longint'(a);
      pb = longint'(b);
      if (sgn != 0) begin
        if (a[18]) pa = pa - 524288;
        if (b[16]) pb = pb - 131072;
      end
      p = pa * pb;
`ifdef MYPROJECT_MUL_SAT_EN
      hi = (sgn != 0) ? (longint'(1) << (dw - 1)) - 1 : (longint'(1) << dw) - 1;
      lo = (sgn != 0) ? -(longint'(1) << (dw - 1)) : 0;
      if (p > hi) p = hi;
      if (p < lo) p = lo;
`endif
      res = res | ((64'(p) & ((64'd1 << dw) - 64'd1)) << (l * dw));
    end
    return res;
  endfunction

  for (genvar c = 0; c < 3; c++) begin : g_cfg
    localparam int LN = cfg_lanes(c);
    localparam int DW = cfg_dout(c);
    localparam int SG = cfg_signed(c);

    myproject_mul_if #(
      .DIN0_WIDTH (19),
      .DIN1_WIDTH (17),
      .DOUT_WIDTH (DW),
      .NUM_LANE   (LN),
      .TAG_WIDTH  (8)
    ) bus ();

    assign bus.in_valid  = in_valid;
    assign bus.din0      = din0_all[LN*19-1:0];
    assign bus.din1      = din1_all[LN*17-1:0];
    assign bus.in_tag    = in_tag;
    assign bus.out_ready = out_ready;
    assign valid_w[c]    = bus.out_valid;
    assign ready_w[c]    = bus.in_ready;
    assign dout_w[c]     = 64'(bus.dout);
    assign tag_w[c]      = bus.out_tag;

    myproject_mul_pipe #(
      .DIN0_WIDTH (19),
      .DIN1_WIDTH (17),
      .DOUT_WIDTH (DW),
      .NUM_LANE   (LN),
      .NUM_STAGE  (NS),
      .SIGNED     (SG),
      .TAG_WIDTH  (8)
    ) dut (
      .ap_clk (ap_clk),
      .ap_rst (ap_rst),
      .bus    (bus)
    );

    ent_t q[$];
    int   cyc     = 0;
    bit   drained = 1'b0;
    bit   exp_v;
    ent_t ent;

    always @(negedge ap_clk) begin
      if (ap_rst) begin
        check($sformatf("c%0d_rst_valid", c), 64'(bus.out_valid), 64'd0);
        check($sformatf("c%0d_rst_ready", c), 64'(bus.in_ready), 64'd1);
        check($sformatf("c%0d_rst_dout", c), 64'(bus.dout), 64'd0);
        check($sformatf("c%0d_rst_tag", c), 64'(bus.out_tag), 64'd0);
        q.delete();
      end else begin
        check($sformatf("c%0d_in_ready", c), 64'(bus.in_ready),
              64'(!(q.size() == NS && !out_ready)));
        exp_v = 1'b0;
        if (q.size() > 0) exp_v = (cyc - q[0].t) >= NS;
        check($sformatf("c%0d_out_valid", c), 64'(bus.out_valid), 64'(exp_v));
        if (bus.out_valid && q.size() > 0) begin
          check($sformatf("c%0d_dout", c), 64'(bus.dout), q[0].e);
          check($sformatf("c%0d_out_tag", c), 64'(bus.out_tag), 64'(q[0].g));
          if (out_ready) void'(q.pop_front());
        end
        if (in_valid && bus.in_ready) begin
          ent.t = cyc;
          ent.e = model(din0_all, din1_all, LN, DW, SG);
          ent.g = in_tag;
          q.push_back(ent);
        end
        if (final_chk && !drained) begin
          check($sformatf("c%0d_drained", c), 64'(q.size()), 64'd0);
          drained = 1'b1;
        end
      end
      cyc++;
    end
  end

  task automatic set_beat(input logic v, input logic [37:0] a, input logic [33:0] b,
                          input logic [7:0] t);
    in_valid = v;
    din0_all = a;
    din1_all = b;
    in_tag   = t;
  endtask

  task automatic rand_beat(input bit v);
    logic [63:0] ra, rb;
    ra = {$urandom, $urandom};
    rb = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: ra = '1;
      1: rb = '1;
      2: ra = '0;
      default: ;
    endcase
    set_beat(v, ra[37:0], rb[33:0], 8'($urandom));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    ap_rst    = 1'b1;
    out_ready = 1'b1;
    final_chk = 1'b0;
    set_beat(1'b0, '0, '0, '0);
    repeat (3) @(posedge ap_clk);
    #1 ap_rst = 1'b0;

    // Directed beats with hand-computed results
    @(posedge ap_clk); #1 set_beat(1'b1, {19'h7FFFF, 19'h7FFFF}, {17'h1FFFF, 17'h1FFFF}, 8'hA5);
    @(posedge ap_clk); #1 set_beat(1'b1, {19'h40000, 19'h40000}, {17'h10000, 17'h10000}, 8'h3C);
    @(posedge ap_clk); #1 set_beat(1'b1, {19'h00010, 19'h00100}, {17'h00010, 17'h00100}, 8'h5A);
    @(negedge ap_clk);
    check("lat_not_early", 64'(valid_w[0]), 64'd0);
    @(posedge ap_clk); #1 in_valid = 1'b0;
    @(negedge ap_clk);
    check("umax_valid", 64'(valid_w[0]), 64'd1);
    check("umax_dout", dout_w[0], 64'hF_FFF6_0001);
    check("umax_tag", 64'(tag_w[0]), 64'hA5);
    check("sgn_m1_dout", dout_w[1], 64'd1);
    @(negedge ap_clk);
    check("sgn_neg_dout", dout_w[1], 64'h4_0000_0000);
    check("uns_pow_dout", dout_w[0], 64'h4_0000_0000);
    @(negedge ap_clk);
    check("narrow_dout", dout_w[2], SAT_EXP);
    check("narrow_tag", 64'(tag_w[2]), 64'h5A);
    check("small_dout", dout_w[0], 64'h1_0000);
    repeat (3) @(posedge ap_clk);

    // Back-pressure: 5 stalled cycles, then release until 10 accepted
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge ap_clk); #1 out_ready = 1'b0; rand_beat(1'b1);
      @(negedge ap_clk); if (ready_w[0]) acc++;
    end
    check("bp_accepted_stalled", 64'(acc), 64'd3);
    for (int i = 0; i < 60 && acc < 10; i++) begin
      @(posedge ap_clk); #1 out_ready = 1'b1; rand_beat(1'b1);
      @(negedge ap_clk); if (ready_w[0]) acc++;
    end
    check("bp_accepted_total", 64'(acc), 64'd10);
    @(posedge ap_clk); #1 in_valid = 1'b0;
    repeat (8) @(posedge ap_clk);

    // Bubble collapse: gapped input under stall fills every stage
    for (int i = 0; i < 6; i++) begin
      @(posedge ap_clk); #1 out_ready = 1'b0; rand_beat(i % 2 == 0 && i < 5);
    end
    @(negedge ap_clk);
    check("bubble_full_ready", 64'(ready_w[0]), 64'd0);
    check("bubble_full_valid", 64'(valid_w[0]), 64'd1);
    @(posedge ap_clk); #1 out_ready = 1'b1; in_valid = 1'b0;
    repeat (6) @(posedge ap_clk);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      @(posedge ap_clk); #1
      out_ready = ($urandom_range(0, 9) < 7);
      rand_beat($urandom_range(0, 9) < 7);
    end

    // Reset with three beats in flight
    @(posedge ap_clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(posedge ap_clk);
    #1 out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_beat(1'b1);
      @(posedge ap_clk); #1;
    end
    in_valid = 1'b0;
    @(negedge ap_clk);
    check("rst_pre_valid", 64'(valid_w), 64'b111);
    #1 ap_rst = 1'b1;
    #1 check("rst_async_valid", 64'(valid_w), 64'b000);
    check("rst_async_ready", 64'(ready_w), 64'b111);
    repeat (2) @(posedge ap_clk);
    #1 ap_rst = 1'b0; out_ready = 1'b1;
    @(negedge ap_clk);
    check("rst_release_ready", 64'(ready_w), 64'b111);
    for (int i = 0; i < 40; i++) begin
      @(posedge ap_clk); #1
      out_ready = ($urandom_range(0, 9) < 6);
      rand_beat($urandom_range(0, 9) < 6);
    end

    @(posedge ap_clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) @(posedge ap_clk);
    #1 final_chk = 1'b1;
    repeat (2) @(negedge ap_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
